// File: rtl/stream_fifo_pkg.sv
// Shared helpers and constants for the stream FIFO: address-width computation,
// wrap-bit pointer increment, parameter legality checks and the status flag bundle.
package stream_fifo_pkg;

  // Smallest legal values for the configurable parameters.
  localparam int unsigned WIDTH_MIN    = 32'd1;
  localparam int unsigned DEPTH_MIN    = 32'd2;
  localparam int unsigned AF_LEVEL_MIN = 32'd1;

  // Level-derived status flags, kept together so they are registered as one unit.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Ceiling log2, usable in constant (elaboration-time) expressions.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    while ((r < 32'd31) && ((32'd1 << r) < n)) begin
      r = r + 32'd1;
    end
    return r;
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit fifo_is_pow2(input int unsigned n);
    return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
  endfunction

  // Increment a ptr_w-bit pointer. With a power-of-2 depth the address field wraps
  // DEPTH-1 -> 0 and the carry toggles the MSB (wrap bit) automatically.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// DEPTH x WIDTH storage for the stream FIFO: one synchronous write port, one
// asynchronous read port and a load-enabled output register that drives read_data.
module stream_fifo_ram
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_load,
  input  logic              rd_bypass,
  output logic [WIDTH-1:0]  rd_q
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_async_s;
  logic [WIDTH-1:0] rd_q_r;

  assign rd_async_s = mem_r[rd_addr];
  assign rd_q       = rd_q_r;

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Output register: loads the addressed word (or the word being written this edge) and otherwise holds.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_q_r <= {WIDTH{1'b0}};
    end else if (rd_load) begin
      rd_q_r <= rd_bypass ? wr_data : rd_async_s;
    end else begin
      rd_q_r <= rd_q_r;
    end
  end

endmodule

// File: rtl/stream_fifo_sync.sv
// Single-clock stream FIFO with fill level, almost-full/empty thresholds, selectable
// show-ahead or registered read, sticky overflow/underflow flags and synchronous flush.
module stream_fifo_sync
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 1,
  localparam int unsigned ADDR_W  = fifo_clog2(DEPTH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              flush,
  input  logic              write_en,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              read_en,
  output logic [WIDTH-1:0]  read_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 32'd1;
  localparam int unsigned CNT_W = ADDR_W + 32'd1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Reject illegal configurations while elaborating.
  generate
    if ((WIDTH < WIDTH_MIN) || (DEPTH < DEPTH_MIN) || !fifo_is_pow2(DEPTH) ||
        (AF_LEVEL < AF_LEVEL_MIN) || (AF_LEVEL > DEPTH) || (AE_LEVEL >= DEPTH)) begin : g_param_error
      $error("stream_fifo_sync: illegal parameters WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
             WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);
    end
  endgenerate

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_inc_s;
  logic [PTR_W-1:0]  rd_ptr_inc_s;
  logic [PTR_W-1:0]  wr_ptr_next_s;
  logic [PTR_W-1:0]  rd_ptr_next_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  fifo_flags_t       flags_r;
  fifo_flags_t       flags_next_s;
  logic              overflow_r;
  logic              underflow_r;
  logic              overflow_next_s;
  logic              underflow_next_s;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_load_s;
  logic              rd_bypass_s;

  assign wr_ptr_inc_s = PTR_W'(ptr_inc(32'(wr_ptr_r), PTR_W));
  assign rd_ptr_inc_s = PTR_W'(ptr_inc(32'(rd_ptr_r), PTR_W));

  // Accept decisions depend only on registered flags, never on the other request.
  always_comb begin
    push_ok_s = write_en & ~flags_r.full;
    pop_ok_s  = read_en & ~flags_r.empty;
    ram_we_s  = push_ok_s & ~flush;
  end

  // Next pointers, fill level and sticky error flags; flush overrides any push/pop.
  always_comb begin
    wr_ptr_next_s    = wr_ptr_r;
    rd_ptr_next_s    = rd_ptr_r;
    count_next_s     = count_r;
    overflow_next_s  = overflow_r;
    underflow_next_s = underflow_r;
    if (flush) begin
      wr_ptr_next_s    = {PTR_W{1'b0}};
      rd_ptr_next_s    = {PTR_W{1'b0}};
      count_next_s     = {CNT_W{1'b0}};
      overflow_next_s  = 1'b0;
      underflow_next_s = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_next_s = wr_ptr_inc_s;
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_next_s = rd_ptr_inc_s;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
      overflow_next_s  = overflow_r | (write_en & flags_r.full);
      underflow_next_s = underflow_r | (read_en & flags_r.empty);
    end
  end

  // Flags are a registered decode of the fill level, so they always match count.
  always_comb begin
    flags_next_s.full         = (count_next_s == DEPTH_CNT);
    flags_next_s.empty        = (count_next_s == {CNT_W{1'b0}});
    flags_next_s.almost_full  = (count_next_s >= AF_CNT);
    flags_next_s.almost_empty = (count_next_s <= AE_CNT);
  end

  // Read path control: show-ahead keeps the register tracking the next head word,
  // registered mode loads only on an accepted pop.
  always_comb begin
    rd_addr_s   = rd_ptr_r[ADDR_W-1:0];
    rd_load_s   = 1'b0;
    rd_bypass_s = 1'b0;
    if (flush) begin
      rd_load_s   = 1'b0;
      rd_bypass_s = 1'b0;
    end else if (FWFT != 32'd0) begin
      rd_addr_s   = rd_ptr_next_s[ADDR_W-1:0];
      rd_load_s   = (count_next_s != {CNT_W{1'b0}});
      // The word written this edge becomes the head: forward it past the array.
      rd_bypass_s = push_ok_s & (wr_ptr_r[ADDR_W-1:0] == rd_ptr_next_s[ADDR_W-1:0]);
    end else begin
      rd_addr_s   = rd_ptr_r[ADDR_W-1:0];
      rd_load_s   = pop_ok_s;
      rd_bypass_s = 1'b0;
    end
  end

  // State registers: pointers, fill level, decoded flags and sticky errors.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_r             <= {PTR_W{1'b0}};
      rd_ptr_r             <= {PTR_W{1'b0}};
      count_r              <= {CNT_W{1'b0}};
      flags_r.full         <= 1'b0;
      flags_r.empty        <= 1'b1;
      flags_r.almost_full  <= 1'b0;
      flags_r.almost_empty <= 1'b1;
      overflow_r           <= 1'b0;
      underflow_r          <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      flags_r     <= flags_next_s;
      overflow_r  <= overflow_next_s;
      underflow_r <= underflow_next_s;
    end
  end

  stream_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .wr_en     (ram_we_s),
    .wr_addr   (wr_ptr_r[ADDR_W-1:0]),
    .wr_data   (write_data),
    .rd_addr   (rd_addr_s),
    .rd_load   (rd_load_s),
    .rd_bypass (rd_bypass_s),
    .rd_q      (read_data)
  );

  assign full         = flags_r.full;
  assign empty        = flags_r.empty;
  assign almost_full  = flags_r.almost_full;
  assign almost_empty = flags_r.almost_empty;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
